// File: rtl/gb_clk_pkg.sv
// Shared constants and the controller state type for the Game Boy clock-enable generator.
package gb_clk_pkg;

  localparam logic [31:0] INC_DEFAULT_32 = 32'd360287970;
  localparam int          DIV_W          = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd1,
    SWITCH = 2'd2
  } clk_gen_state_t;

endpackage

// File: rtl/gb_phase_acc.sv
// Fractional phase accumulator: increment register, accumulator and registered carry (the tick).
module gb_phase_acc
  import gb_clk_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_32)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             dbl,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             inc_load,
  output logic             tick
);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [ACC_W-1:0] inc_eff;
  logic [ACC_W:0]   sum;

  // Double speed drops the increment MSB; a frozen accumulator never emits a carry.
  always_comb begin
    inc_eff = dbl ? {inc_q[ACC_W-2:0], 1'b0} : inc_q;
    sum     = {1'b0, acc_q} + {1'b0, inc_eff};
    inc_d   = inc_load ? inc_i : inc_q;
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (run) begin
      acc_d   = sum[ACC_W-1:0];
      carry_d = sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q   <= INC_DEFAULT;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign tick = carry_q;

endmodule

// File: rtl/gb_clk_gen.sv
// Game Boy T/M-cycle enable generator with DIV counter, pause handshake and
// optional CGB double speed (enabled by defining GB_CLK_GEN_DOUBLE_SPEED_EN).
module gb_clk_gen
  import gb_clk_pkg::*;
#(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_32)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             inc_load,
  input  logic             speed_req,
  output logic             speed_o,
  input  logic             pause_req,
  output logic             paused,
  input  logic             div_clr,
  output logic             cpu_clk,
  output logic             t_en,
  output logic             m_en,
  output logic [7:0]       div_o
);

  clk_gen_state_t   state_q, state_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             t_en_q, t_en_d;
  logic             m_en_q, m_en_d;
  logic             speed_q, speed_d;
  logic [1:0]       tph_q, tph_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick, t_rise, run, enter_switch;

`ifndef GB_CLK_GEN_DOUBLE_SPEED_EN
  logic unused_speed_req;
  assign unused_speed_req = speed_req;
`endif

  // Decisions are taken only at M-cycle boundaries; a speed change outranks a pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (m_en_q && pause_req) state_d = PAUSE;
`ifdef GB_CLK_GEN_DOUBLE_SPEED_EN
        if (m_en_q && (speed_req != speed_q)) state_d = SWITCH;
`endif
      end
      PAUSE:   if (!pause_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign enter_switch = (state_q == RUN) && (state_d == SWITCH);
  assign run          = (state_q == RUN);

  gb_phase_acc #(
    .ACC_W      (ACC_W),
    .INC_DEFAULT(INC_DEFAULT)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .clr     (enter_switch),
    .dbl     (speed_q),
    .inc_i   (inc_i),
    .inc_load(inc_load),
    .tick    (tick)
  );

  // Entering SWITCH restarts the phase so the SWITCH cycle already shows a clean state.
  always_comb begin
    t_rise    = tick & ~cpu_clk_q;
    cpu_clk_d = tick ? ~cpu_clk_q : cpu_clk_q;
    t_en_d    = t_rise;
    m_en_d    = t_rise & (tph_q == 2'd3);
    tph_d     = t_en_q ? tph_q + 2'd1 : tph_q;
    speed_d   = speed_q;
    if (enter_switch) begin
      cpu_clk_d = 1'b0;
      t_en_d    = 1'b0;
      m_en_d    = 1'b0;
      tph_d     = 2'd0;
`ifdef GB_CLK_GEN_DOUBLE_SPEED_EN
      speed_d   = speed_req;
`endif
    end
    if (div_clr)     div_d = '0;
    else if (t_en_q) div_d = div_q + DIV_W'(1);
    else             div_d = div_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cpu_clk_q <= 1'b0;
      t_en_q    <= 1'b0;
      m_en_q    <= 1'b0;
      speed_q   <= 1'b0;
      tph_q     <= 2'd0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_clk_q <= cpu_clk_d;
      t_en_q    <= t_en_d;
      m_en_q    <= m_en_d;
      speed_q   <= speed_d;
      tph_q     <= tph_d;
      div_q     <= div_d;
    end
  end

  assign speed_o = speed_q;
  assign paused  = (state_q == PAUSE);
  assign cpu_clk = cpu_clk_q;
  assign t_en    = t_en_q;
  assign m_en    = m_en_q;
  assign div_o   = div_q[DIV_W-1:DIV_W-8];

endmodule

// File: tb/tb_gb_clk_gen.sv
// Directed self-checking bench for gb_clk_gen; follows GB_CLK_GEN_DOUBLE_SPEED_EN like the RTL.
module tb_gb_clk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inc_i;
  logic        inc_load;
  logic        speed_req;
  logic        speed_o;
  logic        pause_req;
  logic        paused;
  logic        div_clr;
  logic        cpu_clk;
  logic        t_en;
  logic        m_en;
  logic [7:0]  div_o;

  int checks = 0;
  int errors = 0;

  gb_clk_gen #(
    .ACC_W      (32),
    .INC_DEFAULT(32'd360287970)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (inc_i),
    .inc_load (inc_load),
    .speed_req(speed_req),
    .speed_o  (speed_o),
    .pause_req(pause_req),
    .paused   (paused),
    .div_clr  (div_clr),
    .cpu_clk  (cpu_clk),
    .t_en     (t_en),
    .m_en     (m_en),
    .div_o    (div_o)
  );

  always #5 clk = ~clk;

  // Outputs are read 1 time unit after the active edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inc(input logic [31:0] value);
    inc_i    = value;
    inc_load = 1'b1;
    step();
    inc_load = 1'b0;
  endtask

  task automatic wait_m_en(input int bound, output bit found);
    found = 1'b0;
    for (int c = 0; c < bound && !found; c++) begin
      step();
      if (m_en) found = 1'b1;
    end
  endtask

  // Spacing between the next two t_en pulses, 0 if either does not arrive in time.
  task automatic measure_gap(input int bound, output int gap);
    bit found;
    gap   = 0;
    found = 1'b0;
    for (int c = 0; c < bound && !found; c++) begin
      step();
      if (t_en) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int c = 1; c <= bound && !found; c++) begin
        step();
        if (t_en) begin
          found = 1'b1;
          gap   = c;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inc_i = '0; inc_load = 1'b0; speed_req = 1'b0; pause_req = 1'b0; div_clr = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if ({cpu_clk, t_en, m_en, speed_o, paused} !== 5'b0 || div_o !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_outputs cpu_clk=%b t_en=%b m_en=%b speed_o=%b paused=%b div_o=%h, want all zero",
                 cpu_clk, t_en, m_en, speed_o, paused, div_o);
      end
    end
  endtask

  task automatic test_default_rate();
    int tcount = 0, mcount = 0, last = -1, bad_gap = 0, m_alone = 0;
    rst = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      step();
      if (t_en) begin
        tcount++;
        if (last >= 0 && (c - last) != 23 && (c - last) != 24) bad_gap++;
        last = c;
      end
      if (m_en) begin
        mcount++;
        if (!t_en) m_alone++;
      end
    end
    checks++;
    if (tcount < 838 || tcount > 839) begin
      errors++;
      $display("[TB] FAIL default_t_count got %0d, want 838..839", tcount);
    end
    checks++;
    if (4 * mcount > tcount + 4 || 4 * mcount + 4 < tcount) begin
      errors++;
      $display("[TB] FAIL default_m_count got %0d, want %0d/4 +-1", mcount, tcount);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("[TB] FAIL default_t_spacing got %0d gaps outside 23..24, want 0", bad_gap);
    end
    checks++;
    if (m_alone != 0) begin
      errors++;
      $display("[TB] FAIL m_en_without_t_en got %0d, want 0", m_alone);
    end
  endtask

  task automatic test_exact_divide();
    bit found;
    load_inc(32'h8000_0000);
    repeat (8) step();
    wait_m_en(40, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL divide_m_en_timeout got none in 40 clk, want one");
    end else begin
      for (int k = 1; k < 48; k++) begin
        step();
        checks++;
        if (t_en !== (k % 4 == 0) || m_en !== (k % 16 == 0) || cpu_clk !== (k % 4 < 2)) begin
          errors++;
          $display("[TB] FAIL divide_pattern k=%0d got t_en=%b m_en=%b cpu_clk=%b, want %b %b %b",
                   k, t_en, m_en, cpu_clk, k % 4 == 0, k % 16 == 0, k % 4 < 2);
        end
      end
    end
  endtask

  task automatic test_div();
    bit found = 1'b0;
    for (int c = 0; c < 16 && !found; c++) begin
      step();
      if (t_en) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL div_t_en_timeout got none in 16 clk, want one");
    end else begin
      div_clr = 1'b1;
      step();
      div_clr = 1'b0;
      checks++;
      if (div_o !== 8'h00) begin
        errors++;
        $display("[TB] FAIL div_clear got %h, want 00", div_o);
      end
      repeat (1023) step();
      checks++;
      if (div_o !== 8'h00) begin
        errors++;
        $display("[TB] FAIL div_before_1024 got %h, want 00", div_o);
      end
      step();
      checks++;
      if (div_o !== 8'h01) begin
        errors++;
        $display("[TB] FAIL div_at_1024 got %h, want 01", div_o);
      end
      repeat (1023) step();
      checks++;
      if (div_o !== 8'h01) begin
        errors++;
        $display("[TB] FAIL div_before_2048 got %h, want 01", div_o);
      end
      step();
      checks++;
      if (div_o !== 8'h02) begin
        errors++;
        $display("[TB] FAIL div_at_2048 got %h, want 02", div_o);
      end
    end
  endtask

  task automatic test_pause();
    bit         found;
    int         early = 0, activity = 0, unpaused = 0, div_moved = 0;
    logic [7:0] held_div;
    wait_m_en(40, found);
    repeat (5) step();
    pause_req = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (paused) early++;
      if (m_en) found = 1'b1;
    end
    checks++;
    if (!found || early != 0) begin
      errors++;
      $display("[TB] FAIL pause_entry m_en_found=%b early_paused=%0d, want 1 and 0", found, early);
    end
    step();
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_rise got paused=%b, want 1", paused);
    end
    held_div = div_o;
    repeat (24) begin
      step();
      if (t_en || m_en) activity++;
      if (!paused) unpaused++;
      if (div_o !== held_div) div_moved++;
    end
    checks++;
    if (activity != 0 || unpaused != 0 || div_moved != 0) begin
      errors++;
      $display("[TB] FAIL pause_hold pulses=%0d unpaused=%0d div_changes=%0d, want 0 0 0",
               activity, unpaused, div_moved);
    end
    pause_req = 1'b0;
    step();
    checks++;
    if (paused !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_release got paused=%b, want 0", paused);
    end
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step();
      if (t_en) found = 1'b1;
    end
    checks++;
    if (!found || m_en) begin
      errors++;
      $display("[TB] FAIL resume_first_t_en found=%b m_en=%b, want 1 and 0", found, m_en);
    end else begin
      for (int k = 1; k <= 12; k++) begin
        step();
        checks++;
        if (t_en !== (k % 4 == 0) || m_en !== (k == 12)) begin
          errors++;
          $display("[TB] FAIL resume_pattern k=%0d got t_en=%b m_en=%b, want %b %b",
                   k, t_en, m_en, k % 4 == 0, k == 12);
        end
      end
    end
  endtask

  task automatic test_speed_switch();
    bit found;
    int gap;
    int want_gap;
    load_inc(32'h4000_0000);
    repeat (16) step();
    measure_gap(20, gap);
    checks++;
    if (gap != 8) begin
      errors++;
      $display("[TB] FAIL normal_spacing got %0d, want 8", gap);
    end
    wait_m_en(40, found);
    step();
    speed_req = 1'b1;
    wait_m_en(80, found);
    checks++;
    if (!found || speed_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_m_en found=%b speed_o=%b, want 1 and 0", found, speed_o);
    end
    step();
`ifdef GB_CLK_GEN_DOUBLE_SPEED_EN
    want_gap = 4;
    checks++;
    if (speed_o !== 1'b1 || cpu_clk !== 1'b0 || t_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_cycle speed_o=%b cpu_clk=%b t_en=%b, want 1 0 0", speed_o, cpu_clk, t_en);
    end
`else
    want_gap = 8;
    checks++;
    if (speed_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL speed_disabled got speed_o=%b, want 0", speed_o);
    end
`endif
    measure_gap(20, gap);
    checks++;
    if (gap != want_gap) begin
      errors++;
      $display("[TB] FAIL post_switch_spacing got %0d, want %0d", gap, want_gap);
    end
    checks++;
    if (speed_o !== (want_gap == 4)) begin
      errors++;
      $display("[TB] FAIL speed_steady got %b, want %b", speed_o, want_gap == 4);
    end
  endtask

`ifdef GB_CLK_GEN_DOUBLE_SPEED_EN
  task automatic test_reset_in_switch();
    bit found;
    int gap;
    speed_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    speed_req = 1'b1;
    wait_m_en(200, found);
    step();
    checks++;
    if (!found || speed_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL enter_switch found=%b speed_o=%b, want 1 and 1", found, speed_o);
    end
    rst = 1'b1;
    speed_req = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if (speed_o !== 1'b0 || cpu_clk !== 1'b0 || paused !== 1'b0 || t_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_switch speed_o=%b cpu_clk=%b paused=%b t_en=%b, want 0 0 0 0",
               speed_o, cpu_clk, paused, t_en);
    end
    measure_gap(60, gap);
    checks++;
    if ((gap != 23 && gap != 24) || speed_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_after_switch_reset gap=%0d speed_o=%b, want 23..24 and 0", gap, speed_o);
    end
  endtask
`endif

  task automatic test_reset_mid_pause();
    bit found = 1'b0;
    int gap;
    speed_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_inc(32'h8000_0000);
    pause_req = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (paused) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL pause_before_reset got no pause in 60 clk, want pause");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    pause_req = 1'b0;
    checks++;
    if ({paused, cpu_clk, t_en, m_en, speed_o} !== 5'b0 || div_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_in_pause paused=%b cpu_clk=%b t_en=%b m_en=%b speed_o=%b div_o=%h, want all zero",
               paused, cpu_clk, t_en, m_en, speed_o, div_o);
    end
    measure_gap(60, gap);
    checks++;
    if (gap != 23 && gap != 24) begin
      errors++;
      $display("[TB] FAIL run_after_pause_reset gap=%0d, want 23..24", gap);
    end
  endtask

  task automatic test_inc_zero();
    int activity = 0, pauses = 0;
    speed_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_inc(32'h0000_0000);
    pause_req = 1'b1;
    repeat (1000) begin
      step();
      if (t_en || m_en || cpu_clk) activity++;
      if (paused) pauses++;
    end
    pause_req = 1'b0;
    checks++;
    if (activity != 0) begin
      errors++;
      $display("[TB] FAIL inc_zero_activity got %0d active cycles, want 0", activity);
    end
    checks++;
    if (pauses != 0) begin
      errors++;
      $display("[TB] FAIL inc_zero_pause got %0d paused cycles, want 0", pauses);
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_exact_divide();
    test_div();
    test_pause();
    test_speed_switch();
`ifdef GB_CLK_GEN_DOUBLE_SPEED_EN
    test_reset_in_switch();
`endif
    test_reset_mid_pause();
    test_inc_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
